// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multi-cycle MIPS main control unit with memory wait handshake and timeout watchdog
module multicycle_control_fsm #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] AluOp,
  output logic [1:0] PCSource,
  output logic       InstrDone,
  output logic [1:0] ErrCode,
  output logic [3:0] State
);
  localparam logic [3:0] RST      = 4'd0;
  localparam logic [3:0] FETCH    = 4'd1;
  localparam logic [3:0] DECODE   = 4'd2;
  localparam logic [3:0] EXEC_R   = 4'd3;
  localparam logic [3:0] WB_R     = 4'd4;
  localparam logic [3:0] EXEC_I   = 4'd5;
  localparam logic [3:0] WB_I     = 4'd6;
  localparam logic [3:0] MEM_ADDR = 4'd7;
  localparam logic [3:0] MEM_RD   = 4'd8;
  localparam logic [3:0] WB_MEM   = 4'd9;
  localparam logic [3:0] MEM_WR   = 4'd10;
  localparam logic [3:0] BRANCH   = 4'd11;
  localparam logic [3:0] JUMP     = 4'd12;
  localparam logic [3:0] ERROR    = 4'd13;
  logic [3:0] state, nextState;
  logic [7:0] waitCnt;
  logic [2:0] aluOpI, decAluOp;
  logic       isStore, memState, timeout, pcWrite, pcWriteCond;
  assign State    = state;
  assign memState = state == FETCH || state == MEM_RD || state == MEM_WR;
  assign timeout  = memState && !MemReady && waitCnt == 8'(MEM_WAIT_MAX - 1);
  assign PCEn     = pcWrite | (pcWriteCond & Zero);
  assign decAluOp = Opcode == 6'b001100 ? 3'b011 :
                    Opcode == 6'b001010 ? 3'b100 :
                    Opcode == 6'b001101 ? 3'b101 : 3'b010;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= RST;
      waitCnt <= 8'd0;
      ErrCode <= 2'b00;
      aluOpI  <= 3'b000;
      isStore <= 1'b0;
    end else begin
      state   <= nextState;
      waitCnt <= (memState && !MemReady && nextState == state) ? waitCnt + 8'd1 : 8'd0;
      if (state == DECODE) begin
        aluOpI  <= decAluOp;
        isStore <= Opcode[3];
      end
      // only the transition into ERROR records a code, so the first cause sticks
      if (nextState == ERROR && state != ERROR) ErrCode <= timeout ? 2'b10 : 2'b01;
    end
  end
  always_comb begin
    nextState   = state;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemToReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    AluOp       = 3'b000;
    PCSource    = 2'b00;
    InstrDone   = 1'b0;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    case (state)
      RST: nextState = FETCH;
      FETCH: begin
        MemRead   = 1'b1;
        ALUSrcB   = 2'b01;
        AluOp     = 3'b010;
        IRWrite   = MemReady;
        pcWrite   = MemReady;
        nextState = MemReady ? DECODE : timeout ? ERROR : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        AluOp   = 3'b010;
        case (Opcode)
          6'b000000:                                   nextState = EXEC_R;
          6'b100011, 6'b101011:                        nextState = MEM_ADDR;
          6'b000100:                                   nextState = BRANCH;
          6'b000010:                                   nextState = JUMP;
          6'b001000, 6'b001100, 6'b001010, 6'b001101:  nextState = EXEC_I;
          default:                                     nextState = ERROR;
        endcase
      end
      EXEC_R: begin
        ALUSrcA   = 1'b1;
        nextState = WB_R;
      end
      WB_R: begin
        RegDst    = 1'b1;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        nextState = FETCH;
      end
      EXEC_I: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        AluOp     = aluOpI;
        nextState = WB_I;
      end
      WB_I: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        nextState = FETCH;
      end
      MEM_ADDR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        AluOp     = 3'b010;
        nextState = isStore ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        MemRead   = 1'b1;
        IorD      = 1'b1;
        nextState = MemReady ? WB_MEM : timeout ? ERROR : MEM_RD;
      end
      WB_MEM: begin
        MemToReg  = 1'b1;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        nextState = FETCH;
      end
      MEM_WR: begin
        MemWrite  = 1'b1;
        IorD      = 1'b1;
        InstrDone = MemReady;
        nextState = MemReady ? FETCH : timeout ? ERROR : MEM_WR;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        AluOp       = 3'b001;
        pcWriteCond = 1'b1;
        PCSource    = 2'b01;
        InstrDone   = 1'b1;
        nextState   = FETCH;
      end
      JUMP: begin
        pcWrite   = 1'b1;
        PCSource  = 2'b10;
        InstrDone = 1'b1;
        nextState = FETCH;
      end
      ERROR: nextState = ERROR;
      default: nextState = ERROR;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: vector table + scoreboard for per-instruction latency and control outputs
module tb_multicycle_control_fsm;
  logic       clk = 1'b0;
  logic       rst_n, Zero, MemReady;
  logic [5:0] Opcode;
  logic       PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite, ALUSrcA, InstrDone;
  logic [1:0] ALUSrcB, PCSource, ErrCode;
  logic [2:0] AluOp;
  logic [3:0] State;
  logic [16:0] allOut;
  logic [9:0]  doneOut;
  int asserts = 0;
  int fails = 0;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic       zero;
    int         lowN;
    int         cycles;
    logic [2:0] exAlu;
    logic [9:0] done;
  } vec_t;

  vec_t vecs[11];
  vec_t sb[$];

  multicycle_control_fsm #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .AluOp(AluOp), .PCSource(PCSource), .InstrDone(InstrDone),
    .ErrCode(ErrCode), .State(State)
  );

  always #5 clk = ~clk;

  assign allOut  = {PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite,
                    ALUSrcA, ALUSrcB, AluOp, PCSource, InstrDone};
  assign doneOut = {PCEn, MemWrite, RegWrite, RegDst, MemToReg, PCSource, AluOp};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic runVec(input vec_t v);
    vec_t e;
    int cnt = 1;
    logic [2:0] exAlu = 3'bxxx;
    bit done = 0;
    Opcode = v.op;
    Zero   = v.zero;
    sb.push_back(v);
    while (!done && cnt <= 40) begin
      MemReady = !(cnt >= 4 && cnt < 4 + v.lowN);
      #1;
      if (cnt == 3) exAlu = AluOp;
      if (!MemReady) check({v.name, " wait MemRead/IorD"}, {30'd0, MemRead, IorD}, 32'd3);
      if (InstrDone) done = 1;
      else begin
        tick();
        cnt++;
      end
    end
    e = sb.pop_front();
    if (!done) begin
      asserts++;
      fails++;
      $display("FAIL %s: no InstrDone within 40 cycles", e.name);
    end else begin
      check({e.name, " latency"}, cnt, e.cycles);
      check({e.name, " exec AluOp"}, {29'd0, exAlu}, {29'd0, e.exAlu});
      check({e.name, " done outputs"}, {22'd0, doneOut}, {22'd0, e.done});
    end
    MemReady = 1'b1;
    tick();
    check({e.name, " back to FETCH"}, {28'd0, State}, 32'd1);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    tick();
    check("reset State", {28'd0, State}, 32'd0);
    check("reset outputs", {15'd0, allOut}, 32'd0);
    check("reset ErrCode", {30'd0, ErrCode}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("post-reset FETCH", {28'd0, State}, 32'd1);
  endtask

  initial begin
    vecs[0]  = '{"R",      6'b000000, 1'b0, 0, 4, 3'b000, 10'b0_0_1_1_0_00_000};
    vecs[1]  = '{"ORI",    6'b001101, 1'b0, 0, 4, 3'b101, 10'b0_0_1_0_0_00_000};
    vecs[2]  = '{"SLTI",   6'b001010, 1'b0, 0, 4, 3'b100, 10'b0_0_1_0_0_00_000};
    vecs[3]  = '{"ADDI",   6'b001000, 1'b0, 0, 4, 3'b010, 10'b0_0_1_0_0_00_000};
    vecs[4]  = '{"ANDI",   6'b001100, 1'b0, 0, 4, 3'b011, 10'b0_0_1_0_0_00_000};
    vecs[5]  = '{"LW",     6'b100011, 1'b0, 0, 5, 3'b010, 10'b0_0_1_0_1_00_000};
    vecs[6]  = '{"LWwait", 6'b100011, 1'b0, 3, 8, 3'b010, 10'b0_0_1_0_1_00_000};
    vecs[7]  = '{"SW",     6'b101011, 1'b0, 0, 4, 3'b010, 10'b0_1_0_0_0_00_000};
    vecs[8]  = '{"BEQz1",  6'b000100, 1'b1, 0, 3, 3'b001, 10'b1_0_0_0_0_01_001};
    vecs[9]  = '{"BEQz0",  6'b000100, 1'b0, 0, 3, 3'b001, 10'b0_0_0_0_0_01_001};
    vecs[10] = '{"J",      6'b000010, 1'b0, 0, 3, 3'b000, 10'b1_0_0_0_0_10_000};
    Opcode = 6'd0;
    Zero = 1'b0;
    MemReady = 1'b1;
    rst_n = 1'b0;
    tick();
    doReset();
    for (int i = 0; i < 11; i++) runVec(vecs[i]);
    // reset in the middle of a load's memory wait
    Opcode = 6'b100011;
    MemReady = 1'b1;
    repeat (3) tick();
    MemReady = 1'b0;
    tick();
    check("midwait MEM_RD", {28'd0, State}, 32'd8);
    doReset();
    // timeout in FETCH after 15 consecutive low cycles
    MemReady = 1'b0;
    repeat (14) tick();
    check("timeout still FETCH", {28'd0, State}, 32'd1);
    tick();
    check("timeout ERROR", {28'd0, State}, 32'd13);
    check("timeout ErrCode", {30'd0, ErrCode}, 32'd2);
    MemReady = 1'b1;
    #1;
    check("ERROR outputs", {15'd0, allOut}, 32'd0);
    tick();
    check("ERROR held", {28'd0, State}, 32'd13);
    doReset();
    // ready on the last tolerated cycle completes normally, then illegal opcode
    MemReady = 1'b0;
    repeat (14) tick();
    MemReady = 1'b1;
    Opcode = 6'b111111;
    tick();
    check("boundary DECODE", {28'd0, State}, 32'd2);
    check("boundary ErrCode", {30'd0, ErrCode}, 32'd0);
    tick();
    check("illegal ERROR", {28'd0, State}, 32'd13);
    check("illegal ErrCode", {30'd0, ErrCode}, 32'd1);
    MemReady = 1'b0;
    repeat (20) tick();
    check("sticky ErrCode", {30'd0, ErrCode}, 32'd1);
    check("sticky outputs", {15'd0, allOut}, 32'd0);
    doReset();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
